// File: rtl/physics_scheduler.sv
// Frame-level sequencer: generates the physics tick, latches buttons once per frame,
// steps each particle in order with a per-slot timeout, then pulses a commit.
module physics_scheduler #(
    parameter int unsigned NUM_PARTICLES = 4,
    parameter int unsigned TICK_CYCLES   = 10000,
    parameter int unsigned STEP_TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic [NUM_PARTICLES-1:0] step_done,
    output logic [NUM_PARTICLES-1:0] step_en,
    output logic                     btn_left_q,
    output logic                     btn_right_q,
    output logic                     btn_up_q,
    output logic                     btn_down_q,
    output logic                     frame_commit,
    output logic                     busy,
    output logic [15:0]              frame_count,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int unsigned IDX_W = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1;
    localparam int unsigned TMO_W = $clog2(STEP_TIMEOUT + 1);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_COMMIT
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_c;
    logic                     advance_c;
    logic                     set_tmo_c;
    logic [NUM_PARTICLES-1:0] step_en_d;

    // Next-state, tick counter and slot bookkeeping
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        advance_c = 1'b0;
        set_tmo_c = 1'b0;

        tick_c = run && (cnt_q == CNT_W'(TICK_CYCLES - 1));
        if (!run || (cnt_q == CNT_W'(TICK_CYCLES - 1))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tick_c) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the same cycle as the timeout wins
                if (step_done[idx_q]) begin
                    advance_c = 1'b1;
                end else if (tmo_q == TMO_W'(STEP_TIMEOUT - 1)) begin
                    advance_c = 1'b1;
                    set_tmo_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (advance_c) begin
                    if (idx_q == IDX_W'(NUM_PARTICLES - 1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        step_en_d = (state_d == S_ISSUE) ? (NUM_PARTICLES'(1) << idx_d) : '0;
    end

    // State and registered outputs; outputs track the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            step_en      <= '0;
            btn_left_q   <= 1'b0;
            btn_right_q  <= 1'b0;
            btn_up_q     <= 1'b0;
            btn_down_q   <= 1'b0;
            frame_commit <= 1'b0;
            busy         <= 1'b0;
            frame_count  <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            step_en      <= step_en_d;
            frame_commit <= (state_d == S_COMMIT);
            busy         <= (state_d != S_IDLE);
            if (state_q == S_LATCH) begin
                btn_left_q  <= btn_left;
                btn_right_q <= btn_right;
                btn_up_q    <= btn_up;
                btn_down_q  <= btn_down;
            end
            if (state_q == S_COMMIT) begin
                frame_count <= frame_count + 16'(1);
            end
            if (tick_c && (state_q != S_IDLE)) begin
                overrun <= 1'b1;
            end
            if (set_tmo_c) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_physics_scheduler.sv
// Directed bench for physics_scheduler with TICK_CYCLES=16, STEP_TIMEOUT=8, NUM_PARTICLES=4.
module tb_physics_scheduler;

    logic       clk;
    logic       reset;
    logic       run;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic [3:0] step_done;
    logic [3:0] step_en;
    logic       btn_left_q, btn_right_q, btn_up_q, btn_down_q;
    logic       frame_commit;
    logic       busy;
    logic [15:0] frame_count;
    logic       overrun;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc;
    int c;
    logic bad;

    physics_scheduler #(
        .NUM_PARTICLES(4),
        .TICK_CYCLES  (16),
        .STEP_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .step_done   (step_done),
        .step_en     (step_en),
        .btn_left_q  (btn_left_q),
        .btn_right_q (btn_right_q),
        .btn_up_q    (btn_up_q),
        .btn_down_q  (btn_down_q),
        .frame_commit(frame_commit),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since the last reset release (value k just after the k-th edge)
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_en(input int lim, output int cy);
        cy = -1;
        for (int i = 0; i < lim; i++) begin
            if (step_en != 4'b0) begin
                cy = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_commit(input int lim, output int cy);
        cy = -1;
        for (int i = 0; i < lim; i++) begin
            if (frame_commit) begin
                cy = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_done(input logic [3:0] v);
        @(posedge clk); #1;
        step_done = v;
        @(posedge clk); #1;
        step_done = 4'b0;
    endtask

    task automatic step1;
        @(posedge clk); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b1; step_done = 4'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b1; btn_down = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {step_en, frame_commit, busy, overrun, timeout_err}, 32'h0);
        chk("rst_count", frame_count, 0);
        reset = 1'b0;

        // Frame 1: done one cycle after each step_en, btn_up dropped mid-frame
        for (int i = 0; i < 4; i++) begin
            wait_en(40, c);
            chk("f1_en", step_en, 32'(1) << i);
            chk("f1_en_cyc", c, 17 + 2 * i);
            if (i == 0) btn_up = 1'b0;
            pulse_done(step_en);
        end
        wait_commit(10, c);
        chk("f1_commit_cyc", c, 25);
        step1();
        chk("f1_count", frame_count, 1);
        chk("f1_btn_up_q", btn_up_q, 1);
        chk("f1_other_btn", {btn_left_q, btn_right_q, btn_down_q}, 0);
        chk("f1_flags", {overrun, timeout_err, busy, frame_commit}, 0);

        // Frame 2: btn_up low at LATCH, spurious done[3] during slot 0
        wait_en(20, c);
        chk("f2_en0_cyc", c, 33);
        step1();
        step_done = 4'b1000;
        step1();
        step_done = 4'b0001;
        step1();
        step_done = 4'b0000;
        chk("f2_en1_after_spurious", step_en, 4'b0010);
        chk("f2_en1_cyc", cyc, 36);
        pulse_done(4'b0010);
        pulse_done(4'b0100);
        chk("f2_en3", step_en, 4'b1000);
        repeat (3) step1();
        chk("f2_slot3_waiting", {step_en, busy, frame_commit}, 6'b0000_1_0);
        pulse_done(4'b1000);
        wait_commit(5, c);
        chk("f2_commit_cyc", c, 45);
        step1();
        chk("f2_count", frame_count, 2);
        chk("f2_btn_up_q", btn_up_q, 0);

        // Frame 3: slot 2 never answers and times out after 8 WAIT cycles
        wait_en(20, c);
        chk("f3_en0_cyc", c, 49);
        pulse_done(4'b0001);
        pulse_done(4'b0010);
        chk("f3_en2", step_en, 4'b0100);
        step1();
        wait_en(20, c);
        chk("f3_en3_after_timeout", step_en, 4'b1000);
        chk("f3_en3_cyc", c, 62);
        chk("f3_timeout_err", timeout_err, 1);
        chk("f3_no_overrun_yet", overrun, 0);
        pulse_done(4'b1000);
        wait_commit(5, c);
        chk("f3_commit_cyc", c, 64);
        step1();
        chk("f3_count", frame_count, 3);
        chk("f3_overrun", overrun, 1);

        // Phase B: asynchronous reset, then a long frame overlapping a tick
        reset = 1'b1;
        #1;
        chk("rstB_async", {step_en, busy, overrun, timeout_err, frame_count}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        btn_left = 1'b1;
        wait_en(40, c);
        chk("b_en0_cyc", c, 17);
        pulse_done(4'b0001);
        chk("b_en1", step_en, 4'b0010);
        step1();
        wait_en(20, c);
        chk("b_en2_after_slot1_timeout", {28'(c), step_en}, {28'd28, 4'b0100});
        btn_left = 1'b0;
        pulse_done(4'b0100);
        chk("b_no_overrun_before_tick", overrun, 0);
        pulse_done(4'b1000);
        wait_commit(5, c);
        chk("b_commit_cyc", c, 32);
        step1();
        chk("b_overrun", overrun, 1);
        chk("b_count", frame_count, 1);
        chk("b_btn_left_q", btn_left_q, 1);
        bad = 1'b0;
        while (cyc < 48) begin
            if (step_en != 4'b0 || frame_commit) bad = 1'b1;
            step1();
        end
        chk("b_no_extra_frame", bad, 0);
        chk("b_count_held", frame_count, 1);

        // Phase C: reset during WAIT of slot 1
        wait_en(10, c);
        chk("c_en0_cyc", c, 49);
        pulse_done(4'b0001);
        chk("c_en1", step_en, 4'b0010);
        step1();
        #2;
        reset = 1'b1;
        #1;
        chk("c_async_clear", {step_en, busy, frame_commit, overrun, timeout_err, btn_left_q}, 0);
        chk("c_async_count", frame_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_en(40, c);
        chk("c_restart_en", step_en, 4'b0001);
        chk("c_restart_cyc", c, 17);
        chk("c_no_commit", frame_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
